// File: rtl/i2c_reg_seq_if.sv
// Request/response and i2c_master command bus bundle for i2c_reg_seq.
// slave = sequencer view, master = requester plus i2c_master view.
interface i2c_reg_seq_if #(parameter int C_SZ = 6, parameter int S_SZ = 2);
  logic            req_valid;
  logic            req_ready;
  logic            req_rnw;
  logic [6:0]      req_dev;
  logic [7:0]      req_reg;
  logic [7:0]      req_wdat;
  logic [C_SZ-1:0] cmd;
  logic [7:0]      dat;
  logic            ws;
  logic [S_SZ-1:0] stat;
  logic [7:0]      mdat;
  logic            rsp_valid;
  logic [7:0]      rsp_rdat;
  logic            rsp_err;

  modport slave (
    input  req_valid, req_rnw, req_dev, req_reg, req_wdat, stat, mdat,
    output req_ready, cmd, dat, ws, rsp_valid, rsp_rdat, rsp_err
  );
  modport master (
    output req_valid, req_rnw, req_dev, req_reg, req_wdat, stat, mdat,
    input  req_ready, cmd, dat, ws, rsp_valid, rsp_rdat, rsp_err
  );
endinterface

// File: rtl/i2c_reg_seq.sv
// Register read/write sequencer driving an i2c_master command port.
// Optional step timeout: define I2C_REG_SEQ_TIMEOUT_EN.
module i2c_reg_seq #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input logic          clk,
  input logic          aresetn,
  i2c_reg_seq_if.slave bus
);
  localparam logic [5:0] C_STRT = 6'h01;
  localparam logic [5:0] C_STOP = 6'h02;
  localparam logic [5:0] C_READ = 6'h04;
  localparam logic [5:0] C_WRTE = 6'h08;
  localparam logic [5:0] C_NACK = 6'h10;
  localparam logic [5:0] C_CLRS = 6'h20;
  localparam int SB_DON = 0;
  localparam int SB_ERR = 1;

  typedef enum logic [2:0] {IDLE, ISSUE, HOLD, WAIT, CLR, RECOV, RESP} state_t;
  // Which command the shared HOLD/WAIT pair is currently waiting on.
  typedef enum logic [1:0] {PH_NORM, PH_CLR, PH_RECOV, PH_CLR2} phase_t;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [1:0]  step_q, step_d;
  logic [5:0]  cmd_q, cmd_d;
  logic [7:0]  dat_q, dat_d;
  logic [7:0]  rdat_q, rdat_d;
  logic        err_q, err_d;
  logic        rdy_q;
  logic        rnw_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q, wdat_q;
  logic        accept, ws, don, tmo;
  logic [1:0]  last;

  function automatic logic [13:0] step_cmd(input logic [1:0] st, input logic rnw,
                                           input logic [6:0] dev, input logic [7:0] rg,
                                           input logic [7:0] wd);
    case (st)
      2'd0:    step_cmd = {C_STRT | C_WRTE, dev, 1'b0};
      2'd1:    step_cmd = {C_WRTE, rg};
      2'd2:    step_cmd = rnw ? {C_STRT | C_WRTE, dev, 1'b1} : {C_WRTE | C_STOP, wd};
      default: step_cmd = {C_READ | C_NACK | C_STOP, 8'h00};
    endcase
  endfunction

  assign accept = bus.req_valid && rdy_q;
  assign ws     = (state_q == ISSUE) || (state_q == CLR) || (state_q == RECOV);
  assign don    = bus.stat[SB_DON];
  assign last   = rnw_q ? 2'd3 : 2'd2;

`ifdef I2C_REG_SEQ_TIMEOUT_EN
  logic [15:0] tmo_q;
  assign tmo = (state_q == WAIT) && (tmo_q >= TIMEOUT_CYC);
  always_ff @(posedge clk) begin
    if (!aresetn)                             tmo_q <= '0;
    else if (ws)                              tmo_q <= '0;
    else if (state_q == WAIT && tmo_q != '1)  tmo_q <= tmo_q + 16'd1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    step_d  = step_q;
    cmd_d   = cmd_q;
    dat_d   = dat_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = ISSUE;
        phase_d = PH_NORM;
        step_d  = 2'd0;
        err_d   = 1'b0;
        {cmd_d, dat_d} = step_cmd(2'd0, bus.req_rnw, bus.req_dev, bus.req_reg, bus.req_wdat);
        if (!bus.req_rnw) rdat_d = 8'h00;
      end
      ISSUE, CLR, RECOV: state_d = HOLD;
      HOLD: state_d = WAIT;
      WAIT: case (phase_q)
        PH_NORM: if (bus.stat[SB_ERR] || tmo) begin
          state_d = CLR;
          phase_d = PH_CLR;
          err_d   = 1'b1;
          cmd_d   = C_CLRS;
          dat_d   = 8'h00;
        end else if (don) begin
          if (step_q == last) begin
            state_d = RESP;
            if (rnw_q) rdat_d = bus.mdat;
          end else begin
            state_d = ISSUE;
            step_d  = step_q + 2'd1;
            {cmd_d, dat_d} = step_cmd(step_q + 2'd1, rnw_q, dev_q, reg_q, wdat_q);
          end
        end
        PH_CLR: if (tmo) state_d = RESP;
          else if (don) begin
            state_d = RECOV;
            phase_d = PH_RECOV;
            cmd_d   = C_STOP;
            dat_d   = 8'h00;
          end
        // A failed STOP gets one more clear, never a retry loop.
        PH_RECOV: if (tmo) state_d = RESP;
          else if (bus.stat[SB_ERR]) begin
            state_d = CLR;
            phase_d = PH_CLR2;
            cmd_d   = C_CLRS;
            dat_d   = 8'h00;
          end else if (don) state_d = RESP;
        default: if (tmo || don) state_d = RESP;
      endcase
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      phase_q <= PH_NORM;
      step_q  <= 2'd0;
      cmd_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      rnw_q   <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      cmd_q   <= cmd_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
      rdy_q   <= (state_d == IDLE);
      if (accept) begin
        rnw_q  <= bus.req_rnw;
        dev_q  <= bus.req_dev;
        reg_q  <= bus.req_reg;
        wdat_q <= bus.req_wdat;
      end
    end
  end

  assign bus.req_ready = rdy_q;
  assign bus.cmd       = cmd_q;
  assign bus.dat       = dat_q;
  assign bus.ws        = ws;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdat  = rdat_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_i2c_reg_seq.sv
// Bench for i2c_reg_seq: behavioural i2c_master with a register RAM at device 0x3a,
// command/response scoreboard, vector table plus reset, recovery and timeout cases.
module tb_i2c_reg_seq;
  localparam logic [15:0] TMO = 16'd100;
  localparam logic [5:0] C_STRT = 6'h01, C_STOP = 6'h02, C_READ = 6'h04;
  localparam logic [5:0] C_WRTE = 6'h08, C_NACK = 6'h10, C_CLRS = 6'h20;
  localparam logic [6:0] DEV_OK = 7'h3a;

  typedef struct { logic [5:0] cmd; logic [7:0] dat; bit chk_dat; } ws_t;
  typedef struct { logic err; logic [7:0] rdat; int lat; } rsp_t;
  typedef struct { bit rnw; logic [6:0] dev; logic [7:0] rg; logic [7:0] wd;
                   bit exp_err; logic [7:0] exp_rdat; } vec_t;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  i2c_reg_seq_if bus ();
  i2c_reg_seq #(.TIMEOUT_CYC(TMO)) dut (.clk(clk), .aresetn(aresetn), .bus(bus));

  ws_t  exp_ws[$];
  rsp_t exp_rsp[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, acc_cyc = 0, rsp_cnt = 0, ws_cnt = 0, last_ws_cyc = 0, last_rsp_cyc = 0;
  logic ws_prev = 1'b0;
  ws_t  e;
  rsp_t r;

  // i2c_master model
  int         m_dly = 0;
  bit         m_stall = 0, m_stop_err = 0;
  logic [7:0] m_ram [0:255];
  logic [7:0] m_ptr = 8'h00;
  bit         m_ptr_set = 0, m_busy = 0;
  int         m_cnt = 0;
  logic [1:0] m_res = 2'b00, m_tmp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (bus.ws) begin
      m_tmp = 2'b01;
      if (bus.cmd == C_CLRS) m_tmp = 2'b01;
      else if (bus.cmd == C_STOP) m_tmp = m_stop_err ? 2'b10 : 2'b01;
      else if (bus.cmd[0]) begin
        if (bus.dat[7:1] == DEV_OK) m_ptr_set = bus.dat[0];
        else m_tmp = 2'b10;
      end else if (bus.cmd[2]) begin
        bus.mdat <= m_ram[m_ptr];
        m_ptr = m_ptr + 8'd1;
      end else if (bus.cmd[3]) begin
        if (!m_ptr_set) begin m_ptr = bus.dat; m_ptr_set = 1; end
        else begin m_ram[m_ptr] = bus.dat; m_ptr = m_ptr + 8'd1; end
      end
      m_res    <= m_tmp;
      m_busy   <= 1;
      m_cnt    <= m_dly;
      bus.stat <= 2'b00;
    end else if (m_busy && !m_stall) begin
      if (m_cnt == 0) begin bus.stat <= m_res; m_busy <= 0; end
      else m_cnt <= m_cnt - 1;
    end
  end

  // Monitor: pops scoreboard entries on each ws pulse and rsp_valid
  always @(negedge clk) begin
    if (aresetn) begin
      if (bus.ws) begin
        chk("ws_one_cycle", 32'(ws_prev), 32'd0);
        ws_cnt++;
        last_ws_cyc = cyc;
        if (exp_ws.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ws_unexpected: cmd %0h dat %0h, expected no ws", bus.cmd, bus.dat);
        end else begin
          e = exp_ws.pop_front();
          chk("ws_cmd", 32'(bus.cmd), 32'(e.cmd));
          if (e.chk_dat) chk("ws_dat", 32'(bus.dat), 32'(e.dat));
        end
      end
      ws_prev = bus.ws;
      if (bus.rsp_valid) begin
        rsp_cnt++;
        last_rsp_cyc = cyc;
        if (exp_rsp.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rsp_unexpected: err %0b rdat %0h, expected no rsp", bus.rsp_err, bus.rsp_rdat);
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_err", 32'(bus.rsp_err), 32'(r.err));
          chk("rsp_rdat", 32'(bus.rsp_rdat), 32'(r.rdat));
          if (r.lat > 0) chk("latency", 32'(cyc - acc_cyc + 1), 32'(r.lat));
        end
      end
    end else ws_prev = 1'b0;
  end

  task automatic push_seq(input vec_t v, input int lat);
    exp_ws.push_back('{C_STRT | C_WRTE, {v.dev, 1'b0}, 1'b1});
    if (v.dev != DEV_OK) begin
      exp_ws.push_back('{C_CLRS, 8'h00, 1'b0});
      exp_ws.push_back('{C_STOP, 8'h00, 1'b0});
    end else begin
      exp_ws.push_back('{C_WRTE, v.rg, 1'b1});
      if (!v.rnw) exp_ws.push_back('{C_WRTE | C_STOP, v.wd, 1'b1});
      else begin
        exp_ws.push_back('{C_STRT | C_WRTE, {v.dev, 1'b1}, 1'b1});
        exp_ws.push_back('{C_READ | C_NACK | C_STOP, 8'h00, 1'b0});
      end
    end
    exp_rsp.push_back('{v.exp_err, v.exp_rdat, lat});
  endtask

  task automatic send(input vec_t v);
    for (int i = 0; i < 100 && !bus.req_ready; i++) @(negedge clk);
    chk("req_ready_before_send", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_rnw   = v.rnw;
    bus.req_dev   = v.dev;
    bus.req_reg   = v.rg;
    bus.req_wdat  = v.wd;
    acc_cyc = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n0, input int budget);
    for (int i = 0; i < budget && rsp_cnt == n0; i++) @(negedge clk);
    if (rsp_cnt == n0) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_timeout: no rsp_valid within %0d cycles, expected one", budget);
    end
  endtask

  task automatic do_txn(input vec_t v, input int lat);
    int n0;
    n0 = rsp_cnt;
    push_seq(v, lat);
    send(v);
    wait_rsp(n0, 400);
  endtask

  task automatic chk_reset_outs();
    chk("rst_ws", 32'(bus.ws), 32'd0);
    chk("rst_cmd", 32'(bus.cmd), 32'd0);
    chk("rst_dat", 32'(bus.dat), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_rdat", 32'(bus.rsp_rdat), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int n0, w0;
    vecs[0] = '{1'b0, 7'h3a, 8'h00, 8'h11, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 7'h3a, 8'h00, 8'h00, 1'b0, 8'h11};
    vecs[2] = '{1'b0, 7'h10, 8'h00, 8'h55, 1'b1, 8'h00};
    vecs[3] = '{1'b0, 7'h3a, 8'h05, 8'ha5, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 7'h3a, 8'h05, 8'h00, 1'b0, 8'ha5};
    vecs[5] = '{1'b0, 7'h3a, 8'hff, 8'hc3, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 7'h3a, 8'hff, 8'h00, 1'b0, 8'hc3};
    vecs[7] = '{1'b1, 7'h3a, 8'h00, 8'h00, 1'b0, 8'h11};

    bus.req_valid = 1'b0; bus.req_rnw = 1'b0; bus.req_dev = '0;
    bus.req_reg = '0; bus.req_wdat = '0;
    aresetn = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs();
    aresetn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i], (vecs[i].rnw && !vecs[i].exp_err) ? 14 : 11);
      if (i == 0) chk("ram0_after_write", 32'(m_ram[0]), 32'h11);
    end

    // Slow master: function only
    m_dly = 3;
    do_txn('{1'b0, 7'h3a, 8'h40, 8'h5a, 1'b0, 8'h00}, 0);
    do_txn('{1'b1, 7'h3a, 8'h40, 8'h00, 1'b0, 8'h5a}, 0);
    m_dly = 0;

    // STOP fails during recovery: one extra clear, then respond with error
    m_stop_err = 1;
    exp_ws.push_back('{C_STRT | C_WRTE, {7'h10, 1'b0}, 1'b1});
    exp_ws.push_back('{C_CLRS, 8'h00, 1'b0});
    exp_ws.push_back('{C_STOP, 8'h00, 1'b0});
    exp_ws.push_back('{C_CLRS, 8'h00, 1'b0});
    exp_rsp.push_back('{1'b1, 8'h00, 14});
    n0 = rsp_cnt;
    send('{1'b0, 7'h10, 8'h01, 8'h22, 1'b1, 8'h00});
    wait_rsp(n0, 400);
    m_stop_err = 0;
    do_txn('{1'b1, 7'h3a, 8'h05, 8'h00, 1'b0, 8'ha5}, 14);

    // Reset while waiting on step 2
    m_dly = 20;
    w0 = ws_cnt;
    push_seq('{1'b0, 7'h3a, 8'h07, 8'h77, 1'b0, 8'h00}, 0);
    send('{1'b0, 7'h3a, 8'h07, 8'h77, 1'b0, 8'h00});
    for (int i = 0; i < 200 && ws_cnt < w0 + 2; i++) @(negedge clk);
    chk("second_ws_seen", 32'(ws_cnt - w0), 32'd2);
    repeat (4) @(negedge clk);
    aresetn = 1'b0;
    exp_ws.delete();
    exp_rsp.delete();
    @(negedge clk);
    chk_reset_outs();
    aresetn = 1'b1;
    n0 = rsp_cnt;
    repeat (40) @(negedge clk);
    chk("no_rsp_after_abort", 32'(rsp_cnt), 32'(n0));
    m_dly = 0;
    do_txn('{1'b0, 7'h3a, 8'h07, 8'h77, 1'b0, 8'h00}, 11);
    do_txn('{1'b1, 7'h3a, 8'h07, 8'h00, 1'b0, 8'h77}, 14);

    // Master never completes
    m_stall = 1;
    exp_ws.push_back('{C_STRT | C_WRTE, {7'h3a, 1'b0}, 1'b1});
`ifdef I2C_REG_SEQ_TIMEOUT_EN
    exp_ws.push_back('{C_CLRS, 8'h00, 1'b0});
    exp_rsp.push_back('{1'b1, 8'h00, 0});
    n0 = rsp_cnt;
    send('{1'b0, 7'h3a, 8'h09, 8'h99, 1'b0, 8'h00});
    wait_rsp(n0, 600);
    chk("tmo_window", 32'((last_rsp_cyc - last_ws_cyc) <= 110), 32'd1);
`else
    n0 = rsp_cnt;
    send('{1'b0, 7'h3a, 8'h09, 8'h99, 1'b0, 8'h00});
    repeat (10000) @(negedge clk);
    chk("still_busy_ready", 32'(bus.req_ready), 32'd0);
    chk("still_busy_no_rsp", 32'(rsp_cnt), 32'(n0));
    aresetn = 1'b0;
    exp_ws.delete();
    exp_rsp.delete();
    @(negedge clk);
    aresetn = 1'b1;
`endif
    m_stall = 0;
    repeat (5) @(negedge clk);
    do_txn('{1'b0, 7'h3a, 8'h09, 8'h99, 1'b0, 8'h00}, 11);
    do_txn('{1'b1, 7'h3a, 8'h09, 8'h00, 1'b0, 8'h99}, 14);

    repeat (5) @(negedge clk);
    chk("ws_queue_drained", 32'(exp_ws.size()), 32'd0);
    chk("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
